// File: rtl/y86_fetch_pc.sv
// rtl/y86_fetch_pc.sv - Y86-64 SEQ fetch stage with PC register, PC update and sticky status.
// Optional instruction counter enabled by defining FETCH_ICOUNT_EN.
module y86_fetch_pc #(
    parameter int          IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cnd,
    input  logic [63:0] val_m,
    input  logic        load_en,
    input  logic [63:0] load_addr,
    input  logic [7:0]  load_data,
    output logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  r_a,
    output logic [3:0]  r_b,
    output logic [63:0] val_c,
    output logic [63:0] val_p,
    output logic [1:0]  stat,
    output logic [63:0] icount
);

    localparam int          AW      = $clog2(IMEM_BYTES);
    localparam logic [64:0] MEM_TOP = 65'(IMEM_BYTES);

    localparam logic [1:0] ST_AOK = 2'd0;
    localparam logic [1:0] ST_HLT = 2'd1;
    localparam logic [1:0] ST_ADR = 2'd2;
    localparam logic [1:0] ST_INS = 2'd3;

    logic [7:0]  mem [IMEM_BYTES];
    logic [63:0] pc_q;
    logic [1:0]  stat_q;

    logic [64:0] byte_addr [10];
    logic [7:0]  ib [10];

    logic [3:0]  raw_icode;
    logic [3:0]  raw_ifun;
    logic [3:0]  len;
    logic        has_reg;
    logic [1:0]  vc_pos;
    logic        icode_bad;
    logic        ifun_ok;
    logic        adr_err;
    logic        ins_err;
    logic        fetch_ok;
    logic        aok;
    logic        advance;
    logic [63:0] next_pc;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^load_addr[63:AW];

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr[AW-1:0]] <= load_data;
        end
    end

    // Addresses are widened to 65 bits so a PC near 2^64 cannot wrap onto low memory.
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            byte_addr[i] = {1'b0, pc_q} + 65'(i);
            ib[i]        = (byte_addr[i] < MEM_TOP) ? mem[byte_addr[i][AW-1:0]] : 8'h00;
        end
    end

    assign raw_icode = ib[0][7:4];
    assign raw_ifun  = ib[0][3:0];

    always_comb begin
        len       = 4'd1;
        has_reg   = 1'b0;
        vc_pos    = 2'd0;
        icode_bad = 1'b0;
        case (raw_icode)
            4'h0, 4'h1, 4'h9: len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: begin
                len     = 4'd2;
                has_reg = 1'b1;
            end
            4'h7, 4'h8: begin
                len    = 4'd9;
                vc_pos = 2'd1;
            end
            4'h3, 4'h4, 4'h5: begin
                len     = 4'd10;
                has_reg = 1'b1;
                vc_pos  = 2'd2;
            end
            default: icode_bad = 1'b1;
        endcase
    end

    always_comb begin
        ifun_ok = 1'b0;
        case (raw_icode)
            4'h6:       ifun_ok = (raw_ifun <= 4'd3);
            4'h2, 4'h7: ifun_ok = (raw_ifun <= 4'd6);
            default:    ifun_ok = (raw_ifun == 4'd0);
        endcase
    end

    assign adr_err  = ({1'b0, pc_q} + 65'(len) - 65'd1) >= MEM_TOP;
    assign ins_err  = !adr_err && (icode_bad || !ifun_ok);
    assign fetch_ok = !adr_err && !ins_err;

    always_comb begin
        case (vc_pos)
            2'd1:    val_c = {ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2], ib[1]};
            2'd2:    val_c = {ib[9], ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2]};
            default: val_c = 64'd0;
        endcase
    end

    assign val_p = pc_q + 64'(len);
    assign r_a   = has_reg ? ib[1][7:4] : 4'hF;
    assign r_b   = has_reg ? ib[1][3:0] : 4'hF;

    assign aok     = (stat_q == ST_AOK);
    assign advance = aok && !load_en;

    // Anything that must not write back downstream is presented as a nop.
    assign icode = (aok && fetch_ok) ? raw_icode : 4'h1;
    assign ifun  = (aok && fetch_ok) ? raw_ifun  : 4'h0;

    always_comb begin
        if (raw_icode == 4'h8 || (raw_icode == 4'h7 && cnd)) begin
            next_pc = val_c;
        end else if (raw_icode == 4'h9) begin
            next_pc = val_m;
        end else begin
            next_pc = val_p;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            stat_q <= ST_AOK;
        end else if (advance) begin
            if (adr_err) begin
                stat_q <= ST_ADR;
            end else if (ins_err) begin
                stat_q <= ST_INS;
            end else if (raw_icode == 4'h0) begin
                stat_q <= ST_HLT;
            end else begin
                pc_q <= next_pc;
            end
        end
    end

`ifdef FETCH_ICOUNT_EN
    logic [63:0] icount_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icount_q <= 64'd0;
        end else if (advance && fetch_ok) begin
            icount_q <= icount_q + 64'd1;
        end
    end

    assign icount = icount_q;
`else
    assign icount = 64'd0;
`endif

    assign pc   = pc_q;
    assign stat = stat_q;

endmodule

// File: tb/tb_y86_fetch_pc.sv
// tb/tb_y86_fetch_pc.sv - Directed and randomized checks of y86_fetch_pc against a table-driven model.
module tb_y86_fetch_pc;

    localparam int N = 1024;

    logic        clk;
    logic        rst_n;
    logic        cnd;
    logic [63:0] val_m;
    logic        load_en;
    logic [63:0] load_addr;
    logic [7:0]  load_data;
    logic [63:0] pc;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  r_a;
    logic [3:0]  r_b;
    logic [63:0] val_c;
    logic [63:0] val_p;
    logic [1:0]  stat;
    logic [63:0] icount;

    y86_fetch_pc #(.IMEM_BYTES(N), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n), .cnd(cnd), .val_m(val_m),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .pc(pc), .icode(icode), .ifun(ifun), .r_a(r_a), .r_b(r_b),
        .val_c(val_c), .val_p(val_p), .stat(stat), .icount(icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec  = 0;
    int miss = 0;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        vec++;
        if (o !== e) begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Instruction properties indexed by icode.
    localparam int LEN_TAB [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    localparam int VC_AT   [16] = '{0, 0, 0, 2, 2, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    localparam int HAS_REG [16] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    localparam int FN_MAX  [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};

    typedef struct packed {
        logic [3:0]  ic;
        logic [3:0]  fn;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] vc;
        logic [63:0] vp;
        logic [63:0] np;
        logic [1:0]  err;
    } fet_t;

    logic [7:0]  tm [N];
    logic [63:0] m_pc;
    logic [1:0]  m_st;
    logic [63:0] m_cnt;

    function automatic logic [7:0] rdb(input logic [64:0] a);
        logic [9:0] idx;
        idx = a[9:0];
        return (a < 65'(N)) ? tm[idx] : 8'h00;
    endfunction

    function automatic fet_t model_fetch(input logic [63:0] p, input logic c, input logic [63:0] vm);
        fet_t       f;
        logic [7:0] b0;
        logic [7:0] rb;
        int         ln;
        b0   = rdb({1'b0, p});
        f    = '0;
        f.ic = b0[7:4];
        f.fn = b0[3:0];
        ln   = LEN_TAB[f.ic];
        f.vp = p + 64'(ln);
        rb   = rdb({1'b0, p} + 65'd1);
        f.ra = (HAS_REG[f.ic] != 0) ? rb[7:4] : 4'hF;
        f.rb = (HAS_REG[f.ic] != 0) ? rb[3:0] : 4'hF;
        if (VC_AT[f.ic] != 0) begin
            for (int k = 7; k >= 0; k--) begin
                f.vc = {f.vc[55:0], rdb({1'b0, p} + 65'(VC_AT[f.ic] + k))};
            end
        end
        if ({1'b0, p} + 65'(ln) - 65'd1 >= 65'(N)) f.err = 2'd2;
        else if (FN_MAX[f.ic] < 0 || int'(f.fn) > FN_MAX[f.ic]) f.err = 2'd3;
        else f.err = 2'd0;
        if (f.ic == 4'h8 || (f.ic == 4'h7 && c)) f.np = f.vc;
        else if (f.ic == 4'h9) f.np = vm;
        else f.np = f.vp;
        return f;
    endfunction

    task automatic tick();
        fet_t f;
        @(posedge clk);
        f = model_fetch(m_pc, cnd, val_m);
        if (load_en) begin
            tm[load_addr[9:0]] = load_data;
        end else if (rst_n && m_st == 2'd0) begin
            if (f.err != 2'd0) begin
                m_st = f.err;
            end else begin
`ifdef FETCH_ICOUNT_EN
                m_cnt = m_cnt + 64'd1;
`endif
                if (f.ic == 4'h0) m_st = 2'd1;
                else m_pc = f.np;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag);
        fet_t f;
        logic ok;
        f  = model_fetch(m_pc, cnd, val_m);
        ok = (m_st == 2'd0) && (f.err == 2'd0);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".stat"}, 64'(stat), 64'(m_st));
        chk({tag, ".icount"}, icount, m_cnt);
        chk({tag, ".icode"}, 64'(icode), ok ? 64'(f.ic) : 64'h1);
        chk({tag, ".ifun"}, 64'(ifun), ok ? 64'(f.fn) : 64'h0);
        if (ok) begin
            chk({tag, ".r_a"}, 64'(r_a), 64'(f.ra));
            chk({tag, ".r_b"}, 64'(r_b), 64'(f.rb));
            chk({tag, ".val_c"}, val_c, f.vc);
            chk({tag, ".val_p"}, val_p, f.vp);
        end
    endtask

    task automatic load_byte(input logic [63:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic load_prog(input logic [63:0] base, input logic [7:0] q[$]);
        foreach (q[i]) load_byte(base + 64'(i), q[i]);
    endtask

    // Reset is checked mid-cycle to confirm it acts without a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        m_pc  = 64'h0;
        m_st  = 2'd0;
        m_cnt = 64'd0;
        chk("rst.stat", 64'(stat), 64'd0);
        chk("rst.pc", pc, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check_outs(tag);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        rst_n     = 1'b0;
        cnd       = 1'b0;
        val_m     = 64'h0;
        load_en   = 1'b0;
        load_addr = 64'h0;
        load_data = 8'h0;
        m_pc      = 64'h0;
        m_st      = 2'd0;
        m_cnt     = 64'd0;
        for (int i = 0; i < N; i++) tm[i] = 8'h00;
        @(negedge clk);
        for (int i = 0; i < N; i++) load_byte(64'(i), 8'h00);
        chk("reset.pc", pc, 64'h0);
        chk("reset.stat", 64'(stat), 64'd0);
        chk("reset.icount", icount, 64'h0);
        rst_n = 1'b1;

        // Empty memory is a halt at 0.
        check_outs("halt0");
        chk("halt0.icode", 64'(icode), 64'h0);
        tick();
        chk("halt1.stat", 64'(stat), 64'd1);
        chk("halt1.pc", pc, 64'h0);
        check_outs("halt1");

        // irmovq with a full little-endian constant.
        q = '{8'h30, 8'hF3, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        load_prog(64'h0, q);
        do_reset();
        check_outs("irmovq");
        chk("irmovq.r_a", 64'(r_a), 64'hF);
        chk("irmovq.val_c", val_c, 64'h1122334455667788);
        chk("irmovq.val_p", val_p, 64'd10);
        tick();
        chk("irmovq.next_pc", pc, 64'd10);

        // je 0x20 taken and not taken.
        q = '{8'h73, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_prog(64'h0, q);
        do_reset();
        cnd = 1'b1;
        tick();
        chk("je.taken", pc, 64'h20);
        do_reset();
        cnd = 1'b0;
        tick();
        chk("je.fall", pc, 64'h9);

        // ret and call.
        load_byte(64'h0, 8'h90);
        do_reset();
        val_m = 64'h40;
        tick();
        chk("ret.pc", pc, 64'h40);
        q = '{8'h80, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_prog(64'h0, q);
        do_reset();
        check_outs("call");
        chk("call.val_p", val_p, 64'd9);
        tick();
        chk("call.pc", pc, 64'h100);

        // irmovq straddling the top of memory, reached via jmp.
        q = '{8'h70, 8'(N - 5), 8'((N - 5) >> 8), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_prog(64'h0, q);
        q = '{8'h30, 8'hF0, 8'h01, 8'h02, 8'h03};
        load_prog(64'(N - 5), q);
        do_reset();
        cnd = 1'b1;
        tick();
        chk("adr.fetch_pc", pc, 64'(N - 5));
        chk("adr.nop", 64'(icode), 64'h1);
        tick();
        chk("adr.stat", 64'(stat), 64'd2);
        tick();
        chk("adr.frozen", pc, 64'(N - 5));
        check_outs("adr");

        load_byte(64'h0, 8'hC0);
        do_reset();
        tick();
        chk("ins_c0.stat", 64'(stat), 64'd3);
        load_byte(64'h0, 8'h67);
        do_reset();
        chk("ins_67.nop", 64'(icode), 64'h1);
        tick();
        chk("ins_67.stat", 64'(stat), 64'd3);
        do_reset();
        check_outs("after_reset");

        // Five nops then halt.
        q = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00};
        load_prog(64'h0, q);
        do_reset();
        run(8, "count");
`ifdef FETCH_ICOUNT_EN
        chk("count.total", icount, 64'd6);
`else
        chk("count.total", icount, 64'd0);
`endif

        // Randomized instruction streams with random cnd/val_m.
        for (int t = 0; t < 30; t++) begin
            q = {};
            while (q.size() < 40) begin
                int ic;
                int fn;
                ic = $urandom_range(0, 11);
                if (ic == 0 && $urandom_range(0, 3) != 0) ic = 1;
                if ($urandom_range(0, 9) == 0) ic = $urandom_range(0, 15);
                case (ic)
                    6:       fn = $urandom_range(0, 3);
                    2, 7:    fn = $urandom_range(0, 6);
                    default: fn = 0;
                endcase
                if ($urandom_range(0, 9) == 0) fn = $urandom_range(0, 15);
                q.push_back(8'((ic << 4) | fn));
                if (ic < 16 && HAS_REG[ic] != 0) q.push_back(8'($urandom));
                if (ic < 16 && VC_AT[ic] != 0) begin
                    if (ic == 7 || ic == 8) begin
                        q.push_back(8'($urandom_range(0, 40)));
                        for (int k = 0; k < 7; k++) q.push_back(8'h00);
                    end else begin
                        for (int k = 0; k < 8; k++) q.push_back(8'($urandom));
                    end
                end
            end
            load_prog(64'h0, q);
            do_reset();
            for (int c = 0; c < 16; c++) begin
                cnd   = 1'($urandom_range(0, 1));
                val_m = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE
                                                     : 64'($urandom_range(0, 40));
                check_outs("rand");
                tick();
            end
            check_outs("rand_end");
        end

        if (miss != 0) $error("FAIL %0d of %0d vectors miscompared", miss, vec);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/y86_fetch_pc.md
# y86_fetch_pc

SEQ fetch stage with an integrated PC register and PC-update logic, feeding the decode/write-back stage.
- Holds the program counter and a byte-addressed instruction memory.
- Splits the instruction at PC into icode/ifun/rA/rB/valC/valP.
- Computes the next PC from Cnd and valM, and tracks the sticky processor status (AOK/HLT/ADR/INS).

## Interface
- IMEM_BYTES, 1024, instruction memory size in bytes (power of two, ≥16).
- RESET_PC, 64'h0, PC value loaded on reset.
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- cnd  input  1  branch/cmov condition from execute, same cycle.
- val_m  input  64  memory read data, same cycle; return target for ret.
- load_en  input  1  program-load write strobe.
- load_addr  input  64  program-load byte address; only low log2(IMEM_BYTES) bits are used.
- load_data  input  8  program-load byte.
- pc  output  64  current PC register.
- icode  output  4  instruction code (high nibble of byte 0).
- ifun  output  4  function code (low nibble of byte 0).
- r_a  output  4  register-byte high nibble; 4'hF if the instruction has no register byte.
- r_b  output  4  register-byte low nibble; 4'hF if the instruction has no register byte.
- val_c  output  64  little-endian constant; 0 if the instruction has none.
- val_p  output  64  PC + instruction length.
- stat  output  2  processor status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- icount  output  64  fetched-instruction counter (see Configuration).

## Operation
**Instruction length by icode**
- 0 (halt), 1 (nop), 9 (ret): 1 byte.
- 2 (cmov), 6 (opq), A (push), B (pop): 2 bytes.
- 7 (jXX), 8 (call): 9 bytes; valC starts at byte 1.
- 3 (irmovq), 4 (rmmovq), 5 (mrmovq): 10 bytes; valC starts at byte 2.

**Fetch path**
- Combinational, from the pc register: asynchronous byte reads, 10 bytes starting at pc.

**Error checks, in priority order**
- ADR: pc+len-1 ≥ IMEM_BYTES.
- INS: icode > 4'hB.
- INS: opq with ifun > 3.
- INS: jXX/cmov with ifun > 6.
- INS: any other icode with ifun ≠ 0.

**Next PC**
- call, or jXX with cnd=1: val_c.
- ret: val_m.
- Otherwise: val_p.

**Status FSM** (states AOK, HLT, ADR, INS)
- AOK→HLT: fetched icode = 0.
- AOK→ADR / AOK→INS: the corresponding check fails.
- Non-AOK states are sticky until reset.
- In a non-AOK state: pc is frozen, and icode/ifun are forced to 1/0 (nop) so downstream performs no write-back.
- An errored instruction is also output as a nop in its own fetch cycle.

**Program load**
- When load_en=1: mem[load_addr] ← load_data on posedge.
- pc holds, stat does not change, icount does not increment.

**Reset**
- Sets pc=RESET_PC, stat=AOK, icount=0.
- Does not clear memory; initial memory contents are 0.

## Timing
- pc, stat and icount update on posedge clk.
- Fetch outputs are valid combinationally from pc within the same cycle.
- cnd and val_m must settle before posedge. Decode/write-back commits on negedge, so one SEQ instruction completes per cycle.
- Reset values while rst_n=0: pc=RESET_PC, stat=0, icount=0; fetch outputs reflect mem at RESET_PC.
- Asserting rst_n mid-operation (including in HLT/ADR/INS) returns to AOK immediately, without waiting for a clock edge.
- pc arithmetic is 64-bit with wrap-around. A wrapped or out-of-range address yields ADR, never an aliased read.

## Configuration
- FETCH_ICOUNT_EN defined: icount increments by 1 at each posedge where stat=AOK, load_en=0, and the fetched instruction is valid. A halt instruction is counted.
- FETCH_ICOUNT_EN undefined: no counter register is built and icount is constant 0.

## Test plan
- Reset with RESET_PC=0 → pc=0, stat=0, icount=0; release reset, empty memory (byte 00) → icode=0, next edge stat=1, pc remains 0.
- Load 30 F3 88 77 66 55 44 33 22 11 at 0 → icode=3, r_a=F, r_b=3, val_c=64'h1122334455667788, val_p=10; next pc=10.
- Load 73 20 00 00 00 00 00 00 00 (je 0x20) at 0: cnd=1 → pc=0x20; cnd=0 → pc=9.
- ret (90) with val_m=0x40 → pc=0x40. call (80, dest 0x100) → pc=0x100, val_p=9.
- irmovq at IMEM_BYTES-5 → stat=2, icode reads 1, pc frozen. Byte C0 → stat=3. Byte 67 (opq ifun 7) → stat=3. Then pulse rst_n low → stat=0, pc=RESET_PC.
- With FETCH_ICOUNT_EN: five nops then halt → icount=6 and stays 6 while in HLT. Without the macro → icount=0 throughout.
